// File: rtl/nv_nvdla_sdp_mrdma_pkg.sv
// Shared definitions for the SDP MRDMA read-request generator: FSM encodings,
// context payload field positions and sizing helpers.
package nv_nvdla_sdp_mrdma_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // ig2cq_pd = {last_of_layer, last_of_line, size-1}
    function automatic int unsigned cq_eol_bit(input int unsigned size_w);
        return size_w;
    endfunction

    function automatic int unsigned cq_eoly_bit(input int unsigned size_w);
        return size_w + 1;
    endfunction

    // Credit counter must hold the value CDT_DEPTH itself.
    function automatic int unsigned credit_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic logic [13:0] burst_len(input logic [13:0] rem, input int unsigned burst_max);
        return (rem > 14'(burst_max)) ? 14'(burst_max) : rem;
    endfunction

endpackage

// File: rtl/nv_nvdla_sdp_mrdma_cube_walk.sv
// Walks surface/line/atom positions of the cube and presents the current
// burst (address, size, end-of-line/layer flags) from registers.
module nv_nvdla_sdp_mrdma_cube_walk
    import nv_nvdla_sdp_mrdma_pkg::*;
#(
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned ATOM_BYTES = 32,
    parameter int unsigned ATOM_CH    = 8,
    parameter int unsigned BURST_MAX  = 8,
    parameter int unsigned SIZE_W     = 4
) (
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rstn,
    input  logic              load,
    input  logic              advance,
    input  logic [12:0]       cfg_width,
    input  logic [12:0]       cfg_height,
    input  logic [12:0]       cfg_channel,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0] cfg_line_stride,
    input  logic [ADDR_W-1:0] cfg_surf_stride,
    output logic [SIZE_W-1:0] size_m1,
    output logic [ADDR_W-1:0] addr,
    output logic              last_line,
    output logic              last_layer
);
    localparam int unsigned ATOM_SHIFT = $clog2(ATOM_BYTES);
    localparam int unsigned CH_SHIFT   = $clog2(ATOM_CH);
    localparam logic [13:0] BM14       = 14'(BURST_MAX);

    logic [12:0]       width_q, width_d, height_q, height_d, surf_last_q, surf_last_d;
    logic [12:0]       line_q, line_d, surf_q, surf_d;
    logic [13:0]       rem_q, rem_d, burst;
    logic [ADDR_W-1:0] lstride_q, lstride_d, sstride_q, sstride_d;
    logic [ADDR_W-1:0] addr_q, addr_d, line_base_q, line_base_d, surf_base_q, surf_base_d;
    logic [SIZE_W-1:0] size_m1_q, size_m1_d;
    logic              eol_q, eol_d, eoly_q, eoly_d;
    logic [SIZE_W:0]   step;

    // Next position: bases advance incrementally by stride, so no multipliers.
    always_comb begin
        width_d     = width_q;
        height_d    = height_q;
        surf_last_d = surf_last_q;
        lstride_d   = lstride_q;
        sstride_d   = sstride_q;
        line_d      = line_q;
        surf_d      = surf_q;
        rem_d       = rem_q;
        addr_d      = addr_q;
        line_base_d = line_base_q;
        surf_base_d = surf_base_q;
        size_m1_d   = size_m1_q;
        eol_d       = eol_q;
        eoly_d      = eoly_q;
        step        = (SIZE_W+1)'(size_m1_q) + (SIZE_W+1)'(1);
        if (load) begin
            width_d     = cfg_width;
            height_d    = cfg_height;
            surf_last_d = 13'(cfg_channel >> CH_SHIFT);
            lstride_d   = cfg_line_stride;
            sstride_d   = cfg_surf_stride;
            line_d      = 13'd0;
            surf_d      = 13'd0;
            rem_d       = {1'b0, cfg_width} + 14'd1;
            addr_d      = cfg_base;
            line_base_d = cfg_base;
            surf_base_d = cfg_base;
        end else if (advance) begin
            if (eol_q) begin
                rem_d = {1'b0, width_q} + 14'd1;
                if (line_q == height_q) begin
                    line_d      = 13'd0;
                    surf_d      = surf_q + 13'd1;
                    surf_base_d = surf_base_q + sstride_q;
                    line_base_d = surf_base_d;
                    addr_d      = surf_base_d;
                end else begin
                    line_d      = line_q + 13'd1;
                    line_base_d = line_base_q + lstride_q;
                    addr_d      = line_base_d;
                end
            end else begin
                rem_d  = rem_q - 14'(step);
                addr_d = addr_q + (ADDR_W'(step) << ATOM_SHIFT);
            end
        end
        burst = burst_len(rem_d, BURST_MAX);
        if (load || advance) begin
            size_m1_d = SIZE_W'(burst - 14'd1);
            eol_d     = (rem_d <= BM14);
            eoly_d    = eol_d && (line_d == height_d) && (surf_d == surf_last_d);
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            width_q     <= '0;
            height_q    <= '0;
            surf_last_q <= '0;
            lstride_q   <= '0;
            sstride_q   <= '0;
            line_q      <= '0;
            surf_q      <= '0;
            rem_q       <= '0;
            addr_q      <= '0;
            line_base_q <= '0;
            surf_base_q <= '0;
            size_m1_q   <= '0;
            eol_q       <= 1'b0;
            eoly_q      <= 1'b0;
        end else begin
            width_q     <= width_d;
            height_q    <= height_d;
            surf_last_q <= surf_last_d;
            lstride_q   <= lstride_d;
            sstride_q   <= sstride_d;
            line_q      <= line_d;
            surf_q      <= surf_d;
            rem_q       <= rem_d;
            addr_q      <= addr_d;
            line_base_q <= line_base_d;
            surf_base_q <= surf_base_d;
            size_m1_q   <= size_m1_d;
            eol_q       <= eol_d;
            eoly_q      <= eoly_d;
        end
    end

    assign size_m1    = size_m1_q;
    assign addr       = addr_q;
    assign last_line  = eol_q;
    assign last_layer = eoly_q;

endmodule

// File: rtl/nv_nvdla_sdp_mrdma_req_gen.sv
// SDP MRDMA read-request generator: layer FSM, atom credit pool, paired
// DMA/context handshake and DMA stall performance counter.
module nv_nvdla_sdp_mrdma_req_gen
    import nv_nvdla_sdp_mrdma_pkg::*;
#(
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned ATOM_BYTES = 32,
    parameter int unsigned ATOM_CH    = 8,
    parameter int unsigned BURST_MAX  = 8,
    parameter int unsigned CDT_DEPTH  = 64,
    parameter int unsigned SIZE_W     = 4
) (
    input  logic                     nvdla_core_clk,
    input  logic                     nvdla_core_rstn,
    input  logic                     reg2dp_op_en,
    input  logic [12:0]              reg2dp_width,
    input  logic [12:0]              reg2dp_height,
    input  logic [12:0]              reg2dp_channel,
    input  logic [ADDR_W-1:0]        reg2dp_src_base_addr,
    input  logic [ADDR_W-1:0]        reg2dp_src_line_stride,
    input  logic [ADDR_W-1:0]        reg2dp_src_surface_stride,
    input  logic                     reg2dp_perf_dma_en,
    output logic                     dma_rd_req_vld,
    input  logic                     dma_rd_req_rdy,
    output logic [ADDR_W+SIZE_W-1:0] dma_rd_req_pd,
    output logic                     ig2cq_pvld,
    input  logic                     ig2cq_prdy,
    output logic [SIZE_W+1:0]        ig2cq_pd,
    input  logic                     cdt_release,
    output logic                     layer_done,
    output logic [31:0]              dp2reg_mrdma_stall
);
    localparam int unsigned CW       = credit_w(CDT_DEPTH);
    localparam int unsigned EOL_BIT  = cq_eol_bit(SIZE_W);
    localparam int unsigned EOLY_BIT = cq_eoly_bit(SIZE_W);
    localparam logic [CW-1:0] CDT_FULL = CW'(CDT_DEPTH);

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     credit_q, credit_d;
    logic [31:0]       stall_q, stall_d;
    logic              done_q, done_d;
    logic [SIZE_W-1:0] walk_size_m1;
    logic [ADDR_W-1:0] walk_addr;
    logic              walk_eol, walk_eoly;
    logic [SIZE_W:0]   req_size;
    logic [CW:0]       credit_sum;
    logic              run, op_load, credit_ok, accept;

    nv_nvdla_sdp_mrdma_cube_walk #(
        .ADDR_W    (ADDR_W),
        .ATOM_BYTES(ATOM_BYTES),
        .ATOM_CH   (ATOM_CH),
        .BURST_MAX (BURST_MAX),
        .SIZE_W    (SIZE_W)
    ) u_walk (
        .nvdla_core_clk (nvdla_core_clk),
        .nvdla_core_rstn(nvdla_core_rstn),
        .load           (op_load),
        .advance        (accept),
        .cfg_width      (reg2dp_width),
        .cfg_height     (reg2dp_height),
        .cfg_channel    (reg2dp_channel),
        .cfg_base       (reg2dp_src_base_addr),
        .cfg_line_stride(reg2dp_src_line_stride),
        .cfg_surf_stride(reg2dp_src_surface_stride),
        .size_m1        (walk_size_m1),
        .addr           (walk_addr),
        .last_line      (walk_eol),
        .last_layer     (walk_eoly)
    );

    // Both sides must be ready together so DMA request and context never split.
    assign run            = (state_q == ST_RUN);
    assign op_load        = (state_q == ST_IDLE) && reg2dp_op_en;
    assign req_size       = (SIZE_W+1)'(walk_size_m1) + (SIZE_W+1)'(1);
    assign credit_ok      = (credit_q >= CW'(req_size));
    assign accept         = run && credit_ok && dma_rd_req_rdy && ig2cq_prdy;
    assign dma_rd_req_vld = run && credit_ok && ig2cq_prdy;
    assign ig2cq_pvld     = run && credit_ok && dma_rd_req_rdy;
    assign dma_rd_req_pd  = {walk_size_m1, walk_addr};
    assign credit_sum     = {1'b0, credit_q} - (accept ? (CW+1)'(req_size) : '0)
                            + (CW+1)'(cdt_release);

    always_comb begin
        ig2cq_pd               = '0;
        ig2cq_pd[SIZE_W-1:0]   = walk_size_m1;
        ig2cq_pd[EOL_BIT]      = walk_eol;
        ig2cq_pd[EOLY_BIT]     = walk_eoly;
    end

    // Layer FSM, credit pool (clamped at full) and saturating stall counter.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        stall_d  = stall_q;
        done_d   = 1'b0;
        if (state_q != ST_IDLE) begin
            credit_d = (credit_sum > {1'b0, CDT_FULL}) ? CDT_FULL : credit_sum[CW-1:0];
        end
        if (reg2dp_perf_dma_en && dma_rd_req_vld && !dma_rd_req_rdy && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
        case (state_q)
            ST_IDLE: begin
                if (reg2dp_op_en) begin
                    state_d  = ST_RUN;
                    credit_d = CDT_FULL;
                    stall_d  = 32'd0;
                end
            end
            ST_RUN: begin
                if (accept && walk_eoly) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (credit_q == CDT_FULL) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q  <= ST_IDLE;
            credit_q <= CDT_FULL;
            stall_q  <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            stall_q  <= stall_d;
            done_q   <= done_d;
        end
    end

    assign layer_done         = done_q;
    assign dp2reg_mrdma_stall = stall_q;

endmodule

// File: tb/tb_nv_nvdla_sdp_mrdma_req_gen.sv
// Self-checking bench for nv_nvdla_sdp_mrdma_req_gen: directed scenarios plus
// randomized layers against a burst-list / credit reference model.
module tb_nv_nvdla_sdp_mrdma_req_gen;
    localparam int CDT = 16;
    localparam int BM  = 8;

    typedef struct {
        logic [63:0] addr;
        int          size;
        bit          eol;
        bit          eoly;
    } req_t;

    logic        clk, rst_n, op_en, perf, rdy, prdy, rel;
    logic [12:0] width, height, channel;
    logic [63:0] base, lstride, sstride;
    logic        req_vld, cq_pvld, done;
    logic [67:0] req_pd;
    logic [5:0]  cq_pd;
    logic [31:0] stall;

    int   errors = 0;
    int   checks = 0;
    req_t q[$];
    int   ph;          // 0 idle, 1 issuing, 2 waiting for all data back
    int   avail;
    logic [31:0] m_stall;
    bit   exp_done, done_seen;

    nv_nvdla_sdp_mrdma_req_gen #(.CDT_DEPTH(CDT), .BURST_MAX(BM)) dut (
        .nvdla_core_clk           (clk),
        .nvdla_core_rstn          (rst_n),
        .reg2dp_op_en             (op_en),
        .reg2dp_width             (width),
        .reg2dp_height            (height),
        .reg2dp_channel           (channel),
        .reg2dp_src_base_addr     (base),
        .reg2dp_src_line_stride   (lstride),
        .reg2dp_src_surface_stride(sstride),
        .reg2dp_perf_dma_en       (perf),
        .dma_rd_req_vld           (req_vld),
        .dma_rd_req_rdy           (rdy),
        .dma_rd_req_pd            (req_pd),
        .ig2cq_pvld               (cq_pvld),
        .ig2cq_prdy               (prdy),
        .ig2cq_pd                 (cq_pd),
        .cdt_release              (rel),
        .layer_done               (done),
        .dp2reg_mrdma_stall       (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected request list straight from the cube loops.
    task automatic build();
        int a, sz, nsurf;
        q.delete();
        nsurf = (int'(channel) >> 3) + 1;
        for (int s = 0; s < nsurf; s++) begin
            for (int l = 0; l <= int'(height); l++) begin
                a = 0;
                while (a <= int'(width)) begin
                    req_t e;
                    sz     = (int'(width) + 1 - a > BM) ? BM : int'(width) + 1 - a;
                    e.addr = base + 64'(s) * sstride + 64'(l) * lstride + 64'(a) * 64'd32;
                    e.size = sz;
                    e.eol  = (a + sz == int'(width) + 1);
                    e.eoly = e.eol && (l == int'(height)) && (s == nsurf - 1);
                    q.push_back(e);
                    a += sz;
                end
            end
        end
    endtask

    // One clock: check outputs mid-cycle, then advance the reference model.
    task automatic cyc();
        bit ok, acc, ev, ep;
        int sz, pb, nav;
        @(negedge clk);
        pb  = ph;
        ok  = (ph == 1) && (q.size() > 0) && (avail >= q[0].size);
        ev  = ok && prdy;
        ep  = ok && rdy;
        acc = ok && rdy && prdy;
        chk("req_vld", 96'(req_vld), 96'(ev));
        chk("cq_pvld", 96'(cq_pvld), 96'(ep));
        chk("layer_done", 96'(done), 96'(exp_done));
        chk("stall", 96'(stall), 96'(m_stall));
        if (done === 1'b1) done_seen = 1;
        if (ph == 1 && q.size() > 0) begin
            chk("req_pd", 96'(req_pd), 96'({4'(q[0].size - 1), q[0].addr}));
            chk("cq_pd", 96'(cq_pd), 96'({q[0].eoly, q[0].eol, 4'(q[0].size - 1)}));
        end
        exp_done = 0;
        if (perf && ev && !rdy && m_stall != 32'hFFFF_FFFF) m_stall++;
        sz = acc ? q[0].size : 0;
        if (ph == 0) begin
            if (op_en) begin
                build();
                avail   = CDT;
                m_stall = 0;
                ph      = 1;
            end
        end else if (ph == 1) begin
            if (acc) begin
                if (q[0].eoly) ph = 2;
                void'(q.pop_front());
            end
        end else if (avail == CDT) begin
            exp_done = 1;
            ph       = 0;
        end
        if (pb != 0) begin
            nav   = avail - sz + int'(rel);
            avail = (nav > CDT) ? CDT : nav;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int w, input int h, input int c, input logic [63:0] b,
                         input logic [63:0] ls, input logic [63:0] ss);
        width     = 13'(w);
        height    = 13'(h);
        channel   = 13'(c);
        base      = b;
        lstride   = ls;
        sstride   = ss;
        op_en     = 1;
        done_seen = 0;
        cyc();
        op_en     = 0;
    endtask

    task automatic run_to_done(input bit randomize_io, input int budget);
        int n = 0;
        while (!done_seen && n < budget) begin
            if (randomize_io) begin
                rdy  = ($urandom % 4) != 0;
                prdy = ($urandom % 4) != 0;
                rel  = (avail < CDT) ? 1'($urandom % 2) : (($urandom % 8) == 0);
            end else begin
                rdy  = 1;
                prdy = 1;
                rel  = (avail < CDT);
            end
            cyc();
            n++;
        end
        chk("done_seen", 96'(done_seen), 96'(1));
        rel = 0;
    endtask

    initial begin
        clk = 0; rst_n = 0; op_en = 0; perf = 0; rdy = 0; prdy = 0; rel = 0;
        width = 0; height = 0; channel = 0; base = 0; lstride = 0; sstride = 0;
        ph = 0; avail = CDT; m_stall = 0; exp_done = 0; done_seen = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld", 96'(req_vld), 96'(0));
        chk("rst_pvld", 96'(cq_pvld), 96'(0));
        chk("rst_done", 96'(done), 96'(0));
        chk("rst_stall", 96'(stall), 96'(0));
        rst_n = 1;
        cyc();

        // Single line 20 atoms, release one atom per cycle.
        start(19, 0, 7, 64'h1000, 64'h400, 64'h8000);
        run_to_done(0, 200);
        cyc();

        // Credit exhaustion with a 64-atom line.
        start(63, 0, 7, 64'h2_0000, 64'h800, 64'h1_0000);
        rdy = 1; prdy = 1; rel = 0;
        repeat (6) cyc();
        rel = 1; cyc();
        rel = 0; repeat (3) cyc();
        rel = 1; repeat (7) cyc();
        rel = 0; repeat (3) cyc();
        run_to_done(0, 300);

        // Two surfaces by two lines with explicit strides.
        start(3, 1, 15, 64'h4000, 64'h100, 64'h1000);
        run_to_done(0, 200);

        // DMA back-pressure counted as stall, then context back-pressure.
        perf = 1;
        start(15, 0, 7, 64'h8000, 64'h200, 64'h4000);
        rdy = 0; prdy = 1;
        repeat (10) cyc();
        chk("stall_10", 96'(stall), 96'(10));
        rdy = 1; prdy = 0;
        repeat (3) cyc();
        run_to_done(0, 200);

        // Release while full at layer start must be dropped.
        start(7, 0, 7, 64'hA000, 64'h100, 64'h1000);
        rdy = 0; prdy = 0; rel = 1;
        repeat (3) cyc();
        run_to_done(0, 200);

        // Reset in the middle of a layer, then restart from the base address.
        start(40, 0, 7, 64'hC000, 64'h400, 64'h1000);
        rdy = 0; prdy = 1; rel = 0;
        repeat (3) cyc();
        rdy = 1;
        repeat (2) cyc();
        rst_n = 0;
        #1;
        chk("mid_rst_vld", 96'(req_vld), 96'(0));
        chk("mid_rst_pvld", 96'(cq_pvld), 96'(0));
        chk("mid_rst_done", 96'(done), 96'(0));
        chk("mid_rst_stall", 96'(stall), 96'(0));
        chk("mid_rst_pd", 96'(req_pd), 96'(0));
        @(posedge clk);
        #1;
        rst_n = 1;
        ph = 0; avail = CDT; m_stall = 0; exp_done = 0; q.delete();
        cyc();
        start(40, 0, 7, 64'hC000, 64'h400, 64'h1000);
        run_to_done(0, 300);

        // Randomized layers, including high bases that wrap.
        for (int k = 0; k < 8; k++) begin
            perf = 1'($urandom % 2);
            start(int'($urandom_range(0, 20)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 31)), {$urandom, $urandom} & ~64'h1F,
                  64'($urandom_range(0, 4095)) << 5, 64'($urandom_range(0, 65535)) << 5);
            run_to_done(1, 3000);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
